// File: rtl/contador_regressivo.sv
// contador_regressivo -- tenths-of-a-second countdown timer.
//
// Counts down from a preset number of seconds (0..999) in steps of one
// tenth. The displayed value is cont_seg.cont_dec. A prescaler divides clk
// down to one "tenth-tick" every segundo/10 cycles.
//
// State machine:
//   inicio : loaded and idle
//   contar : counting down
//   pausar : paused; the prescaler keeps its partial count
//   parar  : stopped; only carrega or reset leaves this state
//   fim    : reached 0.0; only carrega or reset leaves this state
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; overrides every other input
//   carrega      load preset (accepted in inicio / parar / fim)
//   conta        start / resume request
//   pausa        pause request
//   para         stop request
//   inicial_seg  preset seconds; values above 999 load as 999
//   cont_dec     tenths digit remaining (0..9)
//   cont_seg     seconds remaining (0..999)
//   contando     high while in contar
//   zerado       high while in fim
//   estado       current state encoding
//
// Same-cycle request priority: reset > carrega > para > pausa > conta.
// Every output is a register.
module contador_regressivo #(
  parameter int         segundo = 50000000,
  parameter logic [2:0] inicio  = 3'd0,
  parameter logic [2:0] contar  = 3'd1,
  parameter logic [2:0] pausar  = 3'd2,
  parameter logic [2:0] parar   = 3'd3,
  parameter logic [2:0] fim     = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carrega,
  input  logic       conta,
  input  logic       pausa,
  input  logic       para,
  input  logic [9:0] inicial_seg,
  output logic [3:0] cont_dec,
  output logic [9:0] cont_seg,
  output logic       contando,
  output logic       zerado,
  output logic [2:0] estado
);

  // Cycles per tenth. Held at 1 or more so a tiny segundo still gives
  // a prescaler that can be built.
  localparam int TENTH = ((segundo / 10) < 1) ? 1 : (segundo / 10);
  localparam int PW    = (TENTH > 1) ? $clog2(TENTH) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(TENTH - 1);
  localparam logic [9:0]    SEG_MAX = 10'd999;

  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    est_nxt;
  logic [9:0]    seg_nxt, seg_load;
  logic [3:0]    dec_nxt;
  logic          tick, is_zero, at_last;

  // ---------------------------------------------------------------
  // Next-state / next-value logic
  // ---------------------------------------------------------------
  always_comb begin
    seg_load  = (inicial_seg > SEG_MAX) ? SEG_MAX : inicial_seg;
    tick      = (presc == TICK_AT);
    is_zero   = (cont_seg == 10'd0) && (cont_dec == 4'd0);
    // The decrement that follows this value produces 0.0.
    at_last   = (cont_seg == 10'd0) && (cont_dec == 4'd1);

    est_nxt   = estado;
    seg_nxt   = cont_seg;
    dec_nxt   = cont_dec;
    presc_nxt = presc;

    case (estado)
      inicio: begin
        if (carrega) begin
          seg_nxt   = seg_load;
          dec_nxt   = 4'd0;
          presc_nxt = '0;
          est_nxt   = inicio;
        end else if (para) begin
          est_nxt = parar;
        end else if (conta) begin
          // A zero preset has nothing to count; go straight to fim.
          if (is_zero) begin
            est_nxt = fim;
          end else begin
            est_nxt   = contar;
            presc_nxt = '0;
          end
        end
      end

      contar: begin
        // carrega is ignored while counting. A stop or pause that lands
        // on a tick wins: no decrement, and the prescaler stays put so a
        // resume finishes the interrupted tenth.
        if (para) begin
          est_nxt = parar;
        end else if (pausa) begin
          est_nxt = pausar;
        end else if (is_zero) begin
          // Cannot be reached through normal entry. If it ever is, stop
          // here so the value never wraps below zero.
          est_nxt = fim;
        end else if (tick) begin
          presc_nxt = '0;
          if (cont_dec != 4'd0) begin
            dec_nxt = cont_dec - 4'd1;
          end else begin
            seg_nxt = cont_seg - 10'd1;
            dec_nxt = 4'd9;
          end
          if (at_last) est_nxt = fim;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end

      pausar: begin
        // The prescaler is frozen; carrega and a repeated pausa are ignored.
        if (para) begin
          est_nxt = parar;
        end else if (conta) begin
          est_nxt = contar;
        end
      end

      parar, fim: begin
        // Only a load leaves these states.
        if (carrega) begin
          seg_nxt   = seg_load;
          dec_nxt   = 4'd0;
          presc_nxt = '0;
          est_nxt   = inicio;
        end
      end

      default: begin
        // Unused encodings recover to a clean, empty idle state.
        est_nxt   = inicio;
        seg_nxt   = 10'd0;
        dec_nxt   = 4'd0;
        presc_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------
  // contando and zerado are decoded from the next state, so they change
  // on the same edge as estado and stay registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= inicio;
      cont_seg <= 10'd0;
      cont_dec <= 4'd0;
      presc    <= '0;
      contando <= 1'b0;
      zerado   <= 1'b0;
    end else begin
      estado   <= est_nxt;
      cont_seg <= seg_nxt;
      cont_dec <= dec_nxt;
      presc    <= presc_nxt;
      contando <= (est_nxt == contar);
      zerado   <= (est_nxt == fim);
    end
  end

endmodule
